// File: rtl/rc5_pkg.sv
// ---------------------------------------------------------------------------
// rc5_pkg
// Shared definitions for the RC5-32/12/16 encrypt/decrypt blocks.
//   P32, Q32 : magic constants used to seed the expanded key table
//   ROUNDS   : number of RC5 rounds (12)
//   T        : expanded key table size, 2*ROUNDS+2 (26 words)
//   C        : number of 32-bit key words (4 for a 128-bit key)
//   rotl/rotr: 32-bit rotates, amount taken from the low 5 bits only
//   rc5_state_e : control FSM states {IDLE, KEYEXP, ROUND, FINAL}
// ---------------------------------------------------------------------------
package rc5_pkg;

    localparam logic [31:0] P32    = 32'hB7E15163;
    localparam logic [31:0] Q32    = 32'h9E3779B9;
    localparam int          ROUNDS = 12;
    localparam int          T      = 2 * ROUNDS + 2;
    localparam int          C      = 4;

    typedef enum logic [1:0] {
        IDLE,
        KEYEXP,
        ROUND,
        FINAL
    } rc5_state_e;

    // Rotating a doubled word and keeping one half avoids a variable
    // complementary shift (32 - s), which is awkward when s is zero.
    function automatic logic [31:0] rotl(input logic [31:0] x, input logic [4:0] s);
        logic [63:0] w_d;
        w_d = {x, x} << s;
        return w_d[63:32];
    endfunction

    function automatic logic [31:0] rotr(input logic [31:0] x, input logic [4:0] s);
        logic [63:0] w_d;
        w_d = {x, x} >> s;
        return w_d[31:0];
    endfunction

endpackage

// File: rtl/rc5_key_expand.sv
// ---------------------------------------------------------------------------
// rc5_key_expand
// RC5 key schedule: holds the expanded key table S[0..NWORDS-1] and the key
// word array L[0..C-1], and runs the 3*max(NWORDS,C)-step mixing loop, one
// step per clock. Shared by the encrypt and decrypt blocks.
//
// Ports:
//   i_clk      : clock, rising edge
//   i_rst_n    : asynchronous active-low reset, clears S, L and all state
//   i_start    : load L from i_key, load S with the P32/Q32 constant table,
//                clear X/Y/i/j and begin mixing on the following edges
//   i_key      : 128-bit key, L[k] = i_key[32k+31:32k]
//   i_raddr_a/b: read addresses into S (combinational read)
//   o_rdata_a/b: S[i_raddr_a], S[i_raddr_b]
//   o_done     : high during the cycle whose rising edge performs the final
//                mixing step; S is complete from the next cycle onward
// ---------------------------------------------------------------------------
module rc5_key_expand
    import rc5_pkg::*;
#(
    parameter int NWORDS = T,
    parameter int AW     = $clog2(NWORDS)
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic [32*C-1:0]   i_key,
    input  logic [AW-1:0]     i_raddr_a,
    input  logic [AW-1:0]     i_raddr_b,
    output logic [31:0]       o_rdata_a,
    output logic [31:0]       o_rdata_b,
    output logic              o_done
);

    localparam int STEPS = 3 * ((NWORDS > C) ? NWORDS : C);
    localparam int CW    = $clog2(STEPS);
    localparam int JW    = $clog2(C);

    logic [31:0]   r_s [NWORDS];
    logic [31:0]   r_l [C];
    logic [31:0]   r_x;
    logic [31:0]   r_y;
    logic [AW-1:0] r_i;
    logic [JW-1:0] r_j;
    logic [CW-1:0] r_cnt;
    logic          r_busy;

    logic [31:0]   w_x_new;
    logic [31:0]   w_xy;
    logic [31:0]   w_y_new;

    // One mixing step. Y uses the freshly computed X, both in the sum and
    // in the rotate amount.
    assign w_x_new = rotl(r_s[r_i] + r_x + r_y, 5'd3);
    assign w_xy    = w_x_new + r_y;
    assign w_y_new = rotl(r_l[r_j] + w_xy, w_xy[4:0]);

    assign o_done    = r_busy && (r_cnt == CW'(STEPS - 1));
    assign o_rdata_a = r_s[i_raddr_a];
    assign o_rdata_b = r_s[i_raddr_b];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int k = 0; k < NWORDS; k++) r_s[k] <= '0;
            for (int k = 0; k < C; k++)      r_l[k] <= '0;
            r_x    <= '0;
            r_y    <= '0;
            r_i    <= '0;
            r_j    <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
        end else if (i_start) begin
            // Whole constant table loaded in one cycle.
            for (int k = 0; k < NWORDS; k++) r_s[k] <= P32 + Q32 * 32'(k);
            for (int k = 0; k < C; k++)      r_l[k] <= i_key[32*k +: 32];
            r_x    <= '0;
            r_y    <= '0;
            r_i    <= '0;
            r_j    <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b1;
        end else if (r_busy) begin
            r_s[r_i] <= w_x_new;
            r_l[r_j] <= w_y_new;
            r_x      <= w_x_new;
            r_y      <= w_y_new;
            r_i      <= (r_i == AW'(NWORDS - 1)) ? '0 : r_i + AW'(1);
            r_j      <= (r_j == JW'(C - 1)) ? '0 : r_j + JW'(1);
            r_cnt    <= r_cnt + CW'(1);
            if (o_done) r_busy <= 1'b0;
        end
    end

endmodule

// File: rtl/rc5_decrypt.sv
// ---------------------------------------------------------------------------
// rc5_decrypt
// RC5-32/12/16 block decryptor. A request in IDLE captures the ciphertext
// and key, runs the key schedule (rc5_key_expand), then performs one
// decryption round per clock and presents the plaintext.
//
// Ports:
//   clk    : clock, rising edge
//   clr    : asynchronous active-low reset; aborts any operation in flight
//   din    : ciphertext, A = din[63:32], B = din[31:0]
//   dinKey : 128-bit key, L[0] = dinKey[31:0] ... L[3] = dinKey[127:96]
//   di_vld : request strobe, only looked at in IDLE
//   dout   : plaintext {A,B}, held until the next completion
//   do_vld : one-cycle pulse when dout updates
//
// Timing from the capture edge (edge 0): key schedule on edges 1..78,
// rounds on edges 79..90, result registered on edge 91.
//
// Optional build macro RC5_KEY_CACHE_EN: remembers the key of the last
// completed key schedule; a request with the same key skips the schedule
// and reuses the S table, so the result is registered on edge 13.
// ---------------------------------------------------------------------------
module rc5_decrypt #(
    parameter int ROUNDS = 12,
    parameter int W      = 32
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [2*W-1:0]   din,
    input  logic [4*W-1:0]   dinKey,
    input  logic             di_vld,
    output logic [2*W-1:0]   dout,
    output logic             do_vld
);
    import rc5_pkg::*;

    localparam int NWORDS = 2 * ROUNDS + 2;
    localparam int AW     = $clog2(NWORDS);
    localparam int RW     = $clog2(ROUNDS + 1);

    rc5_state_e    r_state;
    rc5_state_e    w_state_nxt;

    logic [W-1:0]  r_a;
    logic [W-1:0]  r_b;
    logic [RW-1:0] r_round;

    logic          w_capture;
    logic          w_ke_start;
    logic          w_ke_done;
    logic          w_cache_hit;
    logic [AW-1:0] w_raddr_a;
    logic [AW-1:0] w_raddr_b;
    logic [W-1:0]  w_s_a;
    logic [W-1:0]  w_s_b;
    logic [W-1:0]  w_b_new;
    logic [W-1:0]  w_a_new;

    rc5_key_expand #(
        .NWORDS (NWORDS)
    ) u_key_expand (
        .i_clk     (clk),
        .i_rst_n   (clr),
        .i_start   (w_ke_start),
        .i_key     (dinKey),
        .i_raddr_a (w_raddr_a),
        .i_raddr_b (w_raddr_b),
        .o_rdata_a (w_s_a),
        .o_rdata_b (w_s_b),
        .o_done    (w_ke_done)
    );

`ifdef RC5_KEY_CACHE_EN
    logic [4*W-1:0] r_cache_key;
    logic           r_cache_vld;

    assign w_cache_hit = r_cache_vld && (dinKey == r_cache_key);

    // The flag drops while a new schedule is in progress, so an aborted or
    // partial schedule is never mistaken for a valid one.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_cache_key <= '0;
            r_cache_vld <= 1'b0;
        end else if (w_ke_start) begin
            r_cache_key <= dinKey;
            r_cache_vld <= 1'b0;
        end else if (w_ke_done) begin
            r_cache_vld <= 1'b1;
        end
    end
`else
    assign w_cache_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) r_state <= IDLE;
        else      r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_capture   = 1'b0;
        w_ke_start  = 1'b0;
        case (r_state)
            IDLE: begin
                if (di_vld) begin
                    w_capture = 1'b1;
                    if (w_cache_hit) begin
                        w_state_nxt = ROUND;
                    end else begin
                        w_ke_start  = 1'b1;
                        w_state_nxt = KEYEXP;
                    end
                end
            end
            KEYEXP: if (w_ke_done) w_state_nxt = ROUND;
            ROUND:  if (r_round == RW'(1)) w_state_nxt = FINAL;
            FINAL:  w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Rounds read S[2r] and S[2r+1]; the final whitening reads S[0], S[1].
    always_comb begin
        if (r_state == FINAL) begin
            w_raddr_a = '0;
            w_raddr_b = AW'(1);
        end else begin
            w_raddr_a = AW'({r_round, 1'b0});
            w_raddr_b = AW'({r_round, 1'b1});
        end
    end

    // Inverse round: undo B first (it was computed last when encrypting),
    // then undo A using the recovered B.
    assign w_b_new = rotr(r_b - w_s_b, r_a[4:0]) ^ r_a;
    assign w_a_new = rotr(r_a - w_s_a, w_b_new[4:0]) ^ w_b_new;

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_a     <= '0;
            r_b     <= '0;
            r_round <= '0;
            dout    <= '0;
            do_vld  <= 1'b0;
        end else begin
            do_vld <= 1'b0;
            if (w_capture) begin
                r_a     <= din[2*W-1:W];
                r_b     <= din[W-1:0];
                r_round <= RW'(ROUNDS);
            end else if (r_state == ROUND) begin
                r_a     <= w_a_new;
                r_b     <= w_b_new;
                r_round <= r_round - RW'(1);
            end else if (r_state == FINAL) begin
                dout   <= {r_a - w_s_a, r_b - w_s_b};
                do_vld <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_rc5_decrypt.sv
// ---------------------------------------------------------------------------
// tb_rc5_decrypt
// Self-checking bench for rc5_decrypt. Plaintexts are encrypted by an
// RC5-32/12/16 reference model in the bench; the DUT must recover them
// with the expected latency.
// ---------------------------------------------------------------------------
module tb_rc5_decrypt;

    localparam int TB_ROUNDS = 12;
    localparam int TB_T      = 2 * TB_ROUNDS + 2;
    localparam logic [31:0] TB_P = 32'hB7E15163;
    localparam logic [31:0] TB_Q = 32'h9E3779B9;
`ifdef RC5_KEY_CACHE_EN
    localparam bit CACHE_EN = 1'b1;
`else
    localparam bit CACHE_EN = 1'b0;
`endif

    logic          clk;
    logic          clr;
    logic [63:0]   din;
    logic [127:0]  dinKey;
    logic          di_vld;
    logic [63:0]   dout;
    logic          do_vld;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state
    logic [31:0]   m_s [TB_T];
    logic [127:0]  m_cache_key = '0;
    bit            m_cache_vld = 1'b0;

    rc5_decrypt dut (
        .clk    (clk),
        .clr    (clr),
        .din    (din),
        .dinKey (dinKey),
        .di_vld (di_vld),
        .dout   (dout),
        .do_vld (do_vld)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic logic [31:0] rl(input logic [31:0] x, input logic [31:0] amt);
        int sh;
        sh = int'(amt % 32);
        if (sh == 0) return x;
        return (x << sh) | (x >> (32 - sh));
    endfunction

    task automatic model_expand(input logic [127:0] key);
        logic [31:0] l [4];
        logic [31:0] a;
        logic [31:0] b;
        int i;
        int j;
        for (int k = 0; k < 4; k++) l[k] = key[32*k +: 32];
        m_s[0] = TB_P;
        for (int k = 1; k < TB_T; k++) m_s[k] = m_s[k-1] + TB_Q;
        a = 0; b = 0; i = 0; j = 0;
        for (int n = 0; n < 3 * TB_T; n++) begin
            a = rl(m_s[i] + a + b, 32'd3);
            m_s[i] = a;
            b = rl(l[j] + a + b, a + b);
            l[j] = b;
            i = (i + 1) % TB_T;
            j = (j + 1) % 4;
        end
    endtask

    function automatic logic [63:0] model_enc(input logic [63:0] pt);
        logic [31:0] a;
        logic [31:0] b;
        a = pt[63:32] + m_s[0];
        b = pt[31:0] + m_s[1];
        for (int r = 1; r <= TB_ROUNDS; r++) begin
            a = rl(a ^ b, b) + m_s[2*r];
            b = rl(b ^ a, a) + m_s[2*r+1];
        end
        return {a, b};
    endfunction

    function automatic int expected_lat(input logic [127:0] key);
        return (CACHE_EN && m_cache_vld && key == m_cache_key) ? 13 : 91;
    endfunction

    // ---------------- driver ----------------
    // Issues one request and waits for do_vld; lat is the edge count from
    // the capture edge, -1 if no result appeared within the budget.
    task automatic do_op(input logic [63:0] ct, input logic [127:0] key,
                         output logic [63:0] res, output int lat);
        @(negedge clk);
        din = ct; dinKey = key; di_vld = 1'b1;
        @(posedge clk);
        #1;
        di_vld = 1'b0;
        din    = {$urandom, $urandom};
        dinKey = {$urandom, $urandom, $urandom, $urandom};
        lat = -1;
        res = '0;
        for (int n = 1; n <= 200; n++) begin
            @(posedge clk);
            #1;
            if (do_vld) begin
                lat = n;
                res = dout;
                break;
            end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        clr = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            din    = {$urandom, $urandom};
            dinKey = {$urandom, $urandom, $urandom, $urandom};
            di_vld = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
            n_checks++;
            if (dout !== 64'h0) $display("FAIL reset_dout[%0d]: got %h expected %h", c, dout, 64'h0);
            else n_pass++;
            n_checks++;
            if (do_vld !== 1'b0) $display("FAIL reset_do_vld[%0d]: got %b expected 0", c, do_vld);
            else n_pass++;
        end
        @(negedge clk);
        di_vld = 1'b0;
        clr    = 1'b1;
        m_cache_vld = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        n_checks++;
        if (dout !== 64'h0) $display("FAIL post_reset_dout: got %h expected %h", dout, 64'h0);
        else n_pass++;
        n_checks++;
        if (do_vld !== 1'b0) $display("FAIL post_reset_do_vld: got %b expected 0", do_vld);
        else n_pass++;
    endtask

    task automatic test_known_vector();
        logic [63:0] res;
        int lat;
        int exp_lat;
        model_expand(128'h0);
        n_checks++;
        if (model_enc(64'h0) !== 64'hEEDBA521_6D8F4B15)
            $display("FAIL kat_model: got %h expected %h", model_enc(64'h0), 64'hEEDBA521_6D8F4B15);
        else n_pass++;
        exp_lat = expected_lat(128'h0);
        do_op(64'hEEDBA521_6D8F4B15, 128'h0, res, lat);
        n_checks++;
        if (res !== 64'h0) $display("FAIL kat_dout: got %h expected %h", res, 64'h0);
        else n_pass++;
        n_checks++;
        if (lat !== exp_lat) $display("FAIL kat_latency: got %0d expected %0d", lat, exp_lat);
        else n_pass++;
        m_cache_key = 128'h0;
        m_cache_vld = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if (do_vld !== 1'b0) $display("FAIL kat_pulse_width: got %b expected 0", do_vld);
        else n_pass++;
    endtask

    task automatic test_round_trip();
        logic [127:0] key;
        logic [63:0]  pt;
        logic [63:0]  ct;
        logic [63:0]  res;
        int lat;
        int exp_lat;
        for (int v = 0; v < 100; v++) begin
            key = {$urandom, $urandom, $urandom, $urandom};
            pt  = {$urandom, $urandom};
            model_expand(key);
            ct = model_enc(pt);
            exp_lat = expected_lat(key);
            do_op(ct, key, res, lat);
            n_checks++;
            if (res !== pt) $display("FAIL rt_dout[%0d]: got %h expected %h", v, res, pt);
            else n_pass++;
            n_checks++;
            if (lat !== exp_lat) $display("FAIL rt_latency[%0d]: got %0d expected %0d", v, lat, exp_lat);
            else n_pass++;
            m_cache_key = key;
            m_cache_vld = 1'b1;
        end
    endtask

    task automatic test_back_to_back();
        logic [127:0] key1, key2;
        logic [63:0]  pt1, pt2, ct1, ct2, r1, r2;
        int lat1, lat2, n1, n2, pulses;
        key1 = {$urandom, $urandom, $urandom, $urandom};
        key2 = {$urandom, $urandom, $urandom, $urandom};
        pt1  = {$urandom, $urandom};
        pt2  = {$urandom, $urandom};
        model_expand(key1);
        ct1 = model_enc(pt1);
        model_expand(key2);
        ct2 = model_enc(pt2);
        lat1 = expected_lat(key1);
        m_cache_key = key1;
        m_cache_vld = 1'b1;
        lat2 = expected_lat(key2);
        n1 = -1; n2 = -1; r1 = '0; r2 = '0; pulses = 0;
        @(negedge clk);
        din = ct1; dinKey = key1; di_vld = 1'b1;
        @(posedge clk);
        #1;
        // Present the second block immediately; it must not disturb the first.
        din = ct2; dinKey = key2;
        for (int n = 1; n <= 250; n++) begin
            @(posedge clk);
            #1;
            if (do_vld) begin
                if (pulses == 0) begin n1 = n; r1 = dout; end
                else if (pulses == 1) begin n2 = n; r2 = dout; end
                pulses++;
            end
            if (n == lat1 + 1) begin
                di_vld = 1'b0;
                din    = {$urandom, $urandom};
            end
        end
        n_checks++;
        if (pulses !== 2) $display("FAIL b2b_pulses: got %0d expected %0d", pulses, 2);
        else n_pass++;
        n_checks++;
        if (n1 !== lat1) $display("FAIL b2b_lat1: got %0d expected %0d", n1, lat1);
        else n_pass++;
        n_checks++;
        if (r1 !== pt1) $display("FAIL b2b_dout1: got %h expected %h", r1, pt1);
        else n_pass++;
        n_checks++;
        if (n2 !== lat1 + 1 + lat2) $display("FAIL b2b_lat2: got %0d expected %0d", n2, lat1 + 1 + lat2);
        else n_pass++;
        n_checks++;
        if (r2 !== pt2) $display("FAIL b2b_dout2: got %h expected %h", r2, pt2);
        else n_pass++;
        n_checks++;
        if (dout !== pt2) $display("FAIL b2b_dout_hold: got %h expected %h", dout, pt2);
        else n_pass++;
        m_cache_key = key2;
        m_cache_vld = 1'b1;
    endtask

    task automatic test_busy_ignore();
        logic [127:0] key1, key2;
        logic [63:0]  pt1, pt2, ct1, ct2, r1;
        int lat1, n1, pulses, n;
        key1 = {$urandom, $urandom, $urandom, $urandom};
        key2 = {$urandom, $urandom, $urandom, $urandom};
        pt1  = {$urandom, $urandom};
        pt2  = {$urandom, $urandom};
        model_expand(key1);
        ct1 = model_enc(pt1);
        model_expand(key2);
        ct2 = model_enc(pt2);
        lat1 = expected_lat(key1);
        n1 = -1; r1 = '0; pulses = 0;
        @(negedge clk);
        din = ct1; dinKey = key1; di_vld = 1'b1;
        @(posedge clk);
        #1;
        di_vld = 1'b0;
        n = 0;
        // Second request lands on edge 5, while the block is busy.
        for (int k = 0; k < 5; k++) begin
            if (k == 4) begin
                @(negedge clk);
                din = ct2; dinKey = key2; di_vld = 1'b1;
            end
            @(posedge clk);
            #1;
            n++;
            if (do_vld) begin n1 = n; r1 = dout; pulses++; end
        end
        di_vld = 1'b0;
        while (n < lat1 + 100) begin
            @(posedge clk);
            #1;
            n++;
            if (do_vld) begin
                if (pulses == 0) begin n1 = n; r1 = dout; end
                pulses++;
            end
        end
        n_checks++;
        if (pulses !== 1) $display("FAIL busy_pulses: got %0d expected %0d", pulses, 1);
        else n_pass++;
        n_checks++;
        if (n1 !== lat1) $display("FAIL busy_latency: got %0d expected %0d", n1, lat1);
        else n_pass++;
        n_checks++;
        if (r1 !== pt1) $display("FAIL busy_dout: got %h expected %h", r1, pt1);
        else n_pass++;
        m_cache_key = key1;
        m_cache_vld = 1'b1;
    endtask

    task automatic test_mid_reset();
        logic [127:0] key;
        logic [63:0]  pt, ct, res;
        int exp_lat, lat, seen;
        key = {$urandom, $urandom, $urandom, $urandom};
        pt  = {$urandom, $urandom};
        model_expand(key);
        ct = model_enc(pt);
        exp_lat = expected_lat(key);
        @(negedge clk);
        din = ct; dinKey = key; di_vld = 1'b1;
        @(posedge clk);
        #1;
        di_vld = 1'b0;
        // Five edges before completion the block is in ROUND.
        repeat (exp_lat - 5) @(posedge clk);
        #2;
        clr = 1'b0;
        #1;
        n_checks++;
        if (dout !== 64'h0) $display("FAIL midrst_dout: got %h expected %h", dout, 64'h0);
        else n_pass++;
        n_checks++;
        if (do_vld !== 1'b0) $display("FAIL midrst_do_vld: got %b expected 0", do_vld);
        else n_pass++;
        @(negedge clk);
        @(negedge clk);
        clr = 1'b1;
        m_cache_vld = 1'b0;
        seen = 0;
        repeat (100) begin
            @(posedge clk);
            #1;
            if (do_vld) seen++;
        end
        n_checks++;
        if (seen !== 0) $display("FAIL midrst_no_result: got %0d pulses expected %0d", seen, 0);
        else n_pass++;
        // A fresh request after the abort must complete normally.
        key = {$urandom, $urandom, $urandom, $urandom};
        pt  = {$urandom, $urandom};
        model_expand(key);
        ct = model_enc(pt);
        exp_lat = expected_lat(key);
        do_op(ct, key, res, lat);
        n_checks++;
        if (res !== pt) $display("FAIL midrst_recover_dout: got %h expected %h", res, pt);
        else n_pass++;
        n_checks++;
        if (lat !== exp_lat) $display("FAIL midrst_recover_latency: got %0d expected %0d", lat, exp_lat);
        else n_pass++;
        m_cache_key = key;
        m_cache_vld = 1'b1;
    endtask

    task automatic test_same_key();
        logic [127:0] key, key_b;
        logic [63:0]  pt, ct, res;
        int exp_lat, lat;
        key   = {$urandom, $urandom, $urandom, $urandom};
        key_b = {$urandom, $urandom, $urandom, $urandom};
        for (int v = 0; v < 4; v++) begin
            // Sequence: key, key, key_b, key
            logic [127:0] k;
            k  = (v == 2) ? key_b : key;
            pt = {$urandom, $urandom};
            model_expand(k);
            ct = model_enc(pt);
            exp_lat = expected_lat(k);
            do_op(ct, k, res, lat);
            n_checks++;
            if (res !== pt) $display("FAIL samekey_dout[%0d]: got %h expected %h", v, res, pt);
            else n_pass++;
            n_checks++;
            if (lat !== exp_lat) $display("FAIL samekey_latency[%0d]: got %0d expected %0d", v, lat, exp_lat);
            else n_pass++;
            m_cache_key = k;
            m_cache_vld = 1'b1;
        end
    endtask

    initial begin
        clk    = 1'b0;
        clr    = 1'b0;
        din    = '0;
        dinKey = '0;
        di_vld = 1'b0;
        test_reset();
        test_known_vector();
        test_round_trip();
        test_back_to_back();
        test_busy_ignore();
        test_mid_reset();
        test_same_key();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
